// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-requester arbiter.
package arb_pkg;

    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int DEF_MAX_HOLD = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational winner pick: rotate so 'start' is lowest priority, take the
// highest set index, then un-rotate back to a requester index.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   rot_idx;

    // rot[k] = req[(start + k) mod 8], so rot[0] is the previous winner.
    assign dbl = {req, req} >> start;
    assign rot = dbl[N_REQ-1:0];

    // NOTE: every variable driven here gets a default first, otherwise the
    // paths where no bit matches would infer a latch.
    always_comb begin
        rot_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (rot[k]) begin
                rot_idx = IDX_W'(k);
            end
        end
    end

    assign found = |rot;
    assign idx   = start + rot_idx;

endmodule

// File: rtl/req_arbiter8.sv
// 8-requester arbiter: fixed or round-robin pick, grant held while requested,
// forced release after MAX_HOLD cycles, one idle cycle between grants.
module req_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic [IDX_W-1:0]  idx_next;
    logic              timeout_q, timeout_next;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              rel_normal, rel_forced;

    // gnt_idx doubles as the round-robin pointer; fixed mode searches from 7.
    rr_pick8 u_pick (
        .req   (req),
        .start (mode ? gnt_idx : '0),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            gnt_idx   <= idx_next;
            timeout_q <= timeout_next;
        end
    end

    assign rel_normal = !req[gnt_idx] || !en;
    assign rel_forced = (hold_cnt == HOLD_LAST);

    always_comb begin
        state_next   = state;
        hold_next    = hold_cnt;
        idx_next     = gnt_idx;
        timeout_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && pick_found) begin
                    state_next = GRANT;
                    idx_next   = pick_idx;
                    hold_next  = '0;
                end
            end
            GRANT: begin
                if (rel_normal || rel_forced) begin
                    state_next   = IDLE;
                    timeout_next = !rel_normal;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (state == GRANT) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign gnt_valid = (state == GRANT);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed and model-checked random stimulus for req_arbiter8 (MAX_HOLD 16 and 2).
module tb_req_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       en_a, mode_a;
    logic [7:0] req_a, gnt_a;
    logic [2:0] gnt_idx_a;
    logic       gnt_valid_a, timeout_a;

    logic       en_b, mode_b;
    logic [7:0] req_b, gnt_b;
    logic [2:0] gnt_idx_b;
    logic       gnt_valid_b, timeout_b;

    int checks = 0;
    int errors = 0;

    // reference model state for the random run (MAX_HOLD = 16)
    logic       m_valid, m_to;
    int         m_idx, m_hold;

    always #5 clk = ~clk;

    req_arbiter8 #(.MAX_HOLD(16), .HOLD_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .req(req_a),
        .gnt(gnt_a), .gnt_idx(gnt_idx_a), .gnt_valid(gnt_valid_a), .timeout(timeout_a)
    );

    req_arbiter8 #(.MAX_HOLD(2), .HOLD_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .req(req_b),
        .gnt(gnt_b), .gnt_idx(gnt_idx_b), .gnt_valid(gnt_valid_b), .timeout(timeout_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [7:0] g, input logic [2:0] idx,
                           input logic to);
        check({tag, "_gnt"}, 32'(gnt_a), 32'(g));
        check({tag, "_idx"}, 32'(gnt_idx_a), 32'(idx));
        check({tag, "_valid"}, 32'(gnt_valid_a), 32'(g != 8'h00));
        check({tag, "_to"}, 32'(timeout_a), 32'(to));
    endtask

    task automatic model_step();
        logic rel_n, rel_c, hit;
        int   c;
        if (!m_valid) begin
            m_to = 1'b0;
            if (en_a && req_a != 8'h00) begin
                hit = 1'b0;
                for (int i = 1; i <= 8; i++) begin
                    c = mode_a ? ((m_idx - i) & 7) : (8 - i);
                    if (!hit && req_a[c]) begin
                        hit   = 1'b1;
                        m_idx = c;
                    end
                end
                m_valid = 1'b1;
                m_hold  = 0;
            end
        end else begin
            rel_n = !req_a[m_idx] || !en_a;
            rel_c = (m_hold == 15);
            if (rel_n || rel_c) begin
                m_valid = 1'b0;
                m_to    = !rel_n;
            end else begin
                m_hold++;
                m_to = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 1'b1; mode_a = 1'b0; req_a = 8'b0010_0110;
        en_b = 1'b0; mode_b = 1'b0; req_b = 8'h00;
        #3;
        check_a("reset", 8'h00, 3'd0, 1'b0);
        #9 rst_n = 1'b1;

        // fixed priority, held request: forced release after 16 cycles
        tick();
        check_a("fix_first", 8'h20, 3'd5, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        check_a("fix_hold16", 8'h20, 3'd5, 1'b0);
        tick();
        check_a("fix_timeout", 8'h00, 3'd5, 1'b1);
        tick();
        check_a("fix_regrant", 8'h20, 3'd5, 1'b0);

        // normal release of idx 3 while req[6] waits
        req_a = 8'h00;
        tick();
        check_a("rel_idle", 8'h00, 3'd5, 1'b0);
        req_a = 8'h08;
        tick();
        check_a("g3", 8'h08, 3'd3, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        req_a = 8'h40;
        tick();
        check_a("g3_drop", 8'h00, 3'd3, 1'b0);
        tick();
        check_a("g6", 8'h40, 3'd6, 1'b0);

        // en=0 kills an active grant and blocks new ones
        req_a = 8'h00;
        tick();
        req_a = 8'h04;
        tick();
        check_a("g2", 8'h04, 3'd2, 1'b0);
        en_a = 1'b0;
        tick();
        check_a("en0_drop", 8'h00, 3'd2, 1'b0);
        tick();
        tick();
        check_a("en0_hold", 8'h00, 3'd2, 1'b0);
        en_a = 1'b1;
        tick();
        check_a("en1_g2", 8'h04, 3'd2, 1'b0);

        // request drops at the same edge the hold limit is reached
        for (int i = 0; i < 15; i++) tick();
        check_a("corner_pre", 8'h04, 3'd2, 1'b0);
        req_a = 8'h00;
        tick();
        check_a("corner_rel", 8'h00, 3'd2, 1'b0);

        // asynchronous reset mid-grant
        req_a = 8'h04;
        tick();
        check_a("pre_rst", 8'h04, 3'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_a("async_rst", 8'h00, 3'd0, 1'b0);
        #3;
        mode_a = 1'b1; req_a = 8'h01;
        rst_n = 1'b1;
        tick();
        check_a("rr_g0", 8'h01, 3'd0, 1'b0);
        req_a = 8'h00;
        tick();
        req_a = 8'h81;
        tick();
        check_a("rr_ptr0", 8'h80, 3'd7, 1'b0);
        req_a = 8'h00;
        tick();
        req_a = 8'h81;
        tick();
        check_a("rr_ptr7", 8'h01, 3'd0, 1'b0);

        // MAX_HOLD=2 round-robin over all requesters
        req_a = 8'h00;
        en_b = 1'b1; mode_b = 1'b1; req_b = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] e;
            e = 3'(7 - (k % 8));
            tick();
            check("rr2_gnt_a", 32'(gnt_b), 32'(8'h01 << e));
            check("rr2_idx", 32'(gnt_idx_b), 32'(e));
            check("rr2_to_a", 32'(timeout_b), 32'd0);
            tick();
            check("rr2_gnt_b", 32'(gnt_b), 32'(8'h01 << e));
            tick();
            check("rr2_gap", 32'(gnt_b), 32'd0);
            check("rr2_to", 32'(timeout_b), 32'd1);
            check("rr2_valid", 32'(gnt_valid_b), 32'd0);
        end
        en_b = 1'b0;

        // random run against the reference model
        rst_n = 1'b0;
        en_a = 1'b0; req_a = 8'h00; mode_a = 1'b0;
        #2 rst_n = 1'b1;
        m_valid = 1'b0; m_to = 1'b0; m_idx = 0; m_hold = 0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 7) == 0) req_a = 8'($urandom);
            en_a   = ($urandom_range(0, 15) != 0);
            mode_a = 1'($urandom_range(0, 1));
            model_step();
            tick();
            check("rnd_gnt", 32'(gnt_a), m_valid ? 32'(8'h01 << m_idx) : 32'd0);
            check("rnd_idx", 32'(gnt_idx_a), 32'(m_idx));
            check("rnd_to", 32'(timeout_a), 32'(m_to));
            check("rnd_onehot", 32'($onehot0(gnt_a) && (gnt_valid_a == |gnt_a)), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
